regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-read-port register file for the OTTER core, replacing the fixed 32x32 two-read-port file in the decode stage. It adds the following:
- a configurable number of read ports;
- optional write-to-read forwarding;
- a per-register pending scoreboard for multicycle producers, such as loads and divides;
- a sequenced clear of all entries after reset.

Writes are synchronous. Reads are combinational.

## Interface

Parameters:
- XLEN, 32, data width in bits
- DEPTH, 32, number of entries; power of two, at least 2; ADDR_W = $clog2(DEPTH)
- NUM_RD, 2, number of read ports, 1 to 4
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports; 0 = reads see only stored data
- ZERO_REG, 1, 1 = entry 0 reads as 0 and cannot be written or reserved

Ports:
- CLK  in  1  clock; everything is updated on the rising edge
- RST  in  1  synchronous, active-high reset
- EN  in  1  write enable
- WA  in  ADDR_W  write address
- WD  in  XLEN  write data
- RSV_EN  in  1  reserve enable; marks RSV_A pending
- RSV_A  in  ADDR_W  reserve address
- ADR  in  NUM_RD*ADDR_W  read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
- RS  out  NUM_RD*XLEN  read data; port i uses bits [i*XLEN +: XLEN]
- PEND  out  NUM_RD  port i: addressed entry is awaiting a write
- BUSY  out  1  clear sequence in progress; the file is not usable

## Operation

- Two states: CLEAR and READY. Registers: a clear counter cnt (ADDR_W bits), a pend bit vector (DEPTH bits) and the mem array.
- Any rising edge with RST=1:
  - state is set to CLEAR, cnt to 0 and all pend bits to 0.
  - Holding RST keeps cnt at 0.
- CLEAR with RST=0:
  - each cycle writes 0 to mem[cnt] and increments cnt.
  - On the edge that writes mem[DEPTH-1], state moves to READY.
- In CLEAR:
  - EN and RSV_EN are ignored.
  - Every RS port reads 0, every PEND bit is 0 and BUSY is 1.
- Write (READY only): if EN=1, mem[WA] takes WD and pend[WA] is cleared. The write is suppressed when ZERO_REG=1 and WA=0.
- Reserve (READY only): if RSV_EN=1, pend[RSV_A] is set. Ignored when ZERO_REG=1 and RSV_A=0.
- Write and reserve to the same address in one cycle: mem is updated and pend ends at 1, because the new producer takes precedence. For different addresses, both take effect.
- Read port i, combinational, in priority order:
  1. If ZERO_REG=1 and ADR_i=0, RS_i=0 and PEND_i=0.
  2. Otherwise, if BYPASS=1, the state is READY, EN=1 and WA=ADR_i, then RS_i=WD and PEND_i=0. The write is retiring the producer.
  3. Otherwise, RS_i=mem[ADR_i] and PEND_i=pend[ADR_i].
- A reserve never affects PEND in the same cycle; it is visible from the next cycle.
- Any number of ports may read the same address.
- With ZERO_REG=0, entry 0 behaves like any other entry.
- Addresses are always in range because DEPTH is a power of two; there is no wrap handling beyond cnt rolling over at the end of CLEAR.

## Timing

- Values seen after the first RST edge:
  - BUSY=1, PEND=0 and RS=0.
  - These hold while RST=1 and for DEPTH cycles after RST falls.
  - BUSY drops on the DEPTH-th rising edge after RST deasserts.
- Write-to-read latency:
  - 0 cycles with BYPASS=1, since the data appears on RS in the write cycle.
  - 1 cycle with BYPASS=0.
- Reserve-to-PEND latency: 1 cycle.
- Write-to-PEND-clear latency:
  - 0 cycles with BYPASS=1, through the forwarding path.
  - Otherwise 1 cycle.
- RST during CLEAR restarts the sequence at cnt=0; the full DEPTH cycles are needed again.
- RST during READY drops all pending bits on that edge. Stored data is then zeroed by the new CLEAR sequence.
- Before the first RST, the contents and outputs are undefined. The core must assert RST before use.
- No combinational path runs from ADR to BUSY. RS and PEND depend combinationally on ADR, WA, EN and WD only.

## Test plan

- Clear sequence, DEPTH=32:
  - Stimulus: RST high for 3 cycles, then low.
  - BUSY stays 1 for exactly 32 more edges, then drops.
  - After that, every address reads 0 on every port.
  - Pulses of EN=1, WA=5, WD=0xDEAD during CLEAR leave mem[5]=0.
- Write and forward:
  - With BYPASS=1: EN=1, WA=7, WD=0x1234ABCD, ADR0=7 gives RS0=0x1234ABCD in the same cycle.
  - With BYPASS=0, RS0 shows the old value (0) in that cycle and 0x1234ABCD on the next.
- Zero register:
  - With ZERO_REG=1, a write of 0xFFFFFFFF to WA=0 followed by RSV_EN with RSV_A=0 leaves RS=0 and PEND=0 for ADR=0.
  - With ZERO_REG=0, the same write reads back 0xFFFFFFFF.
- Scoreboard:
  - Reserving address 9 gives PEND=1 on every port reading 9 from the next cycle.
  - A write of 0x55 to address 9 clears PEND: in the same cycle with BYPASS=1, on the next cycle with BYPASS=0.
  - A simultaneous write and reserve to address 9 leaves PEND=1 and data=the written value.
- Multi-port: with NUM_RD=4, write distinct values to addresses 1–4, then read all four ports at once. Next read the same address on all ports and confirm every port returns the same value.
- Reset mid-clear:
  - Assert RST when cnt=10 during a clear that follows a READY period in which addresses 20 and 31 held 0xAA and pend[20]=1.
  - BUSY is then held for a full 32 cycles after RST falls.
  - PEND=0 immediately, and addresses 20 and 31 read 0 after BUSY falls.

Source files
------------

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//   Parametrised multi-read-port register file for the OTTER decode stage.
//   Synchronous write, combinational reads, optional write-to-read forwarding,
//   a per-entry pending scoreboard for multicycle producers, and a sequenced
//   clear of every entry after reset.
//
// Parameters
//   XLEN     data width
//   DEPTH    number of entries (power of two, >= 2)
//   NUM_RD   number of read ports (1..4)
//   BYPASS   1: a same-cycle write is forwarded to matching read ports
//   ZERO_REG 1: entry 0 reads as 0 and cannot be written or reserved
//
// Ports
//   CLK     clock, rising edge
//   RST     synchronous active-high reset
//   EN      write enable           WA/WD   write address / data
//   RSV_EN  reserve enable         RSV_A   reserve address
//   ADR     packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   RS      packed read data,      port i at [i*XLEN   +: XLEN]
//   PEND    per-port pending flag for the addressed entry
//   BUSY    clear sequence running; file contents not usable
// -----------------------------------------------------------------------------

// One read port: priority mux between the hard-wired zero entry, the
// forwarded write data and the stored data/pending bit.
module regfile_mp_rdport #(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 5,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              ready_i,
    input  logic [ADDR_W-1:0] adr_i,
    input  logic [XLEN-1:0]   mem_rd_i,
    input  logic              pend_rd_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wa_i,
    input  logic [XLEN-1:0]   wd_i,
    output logic [XLEN-1:0]   rs_o,
    output logic              pend_o
);
    logic zero_hit;
    logic byp_hit;

    assign zero_hit = (ZERO_REG != 0) && (adr_i == '0);
    // A forwarded write is retiring the producer, so PEND reads 0 on a hit.
    assign byp_hit  = (BYPASS != 0) && wr_en_i && (wa_i == adr_i);

    always_comb begin
        rs_o   = '0;
        pend_o = 1'b0;
        // While the clear sequence runs every port reads 0 / not pending.
        if (ready_i && !zero_hit) begin
            if (byp_hit) begin
                rs_o = wd_i;
            end else begin
                rs_o   = mem_rd_i;
                pend_o = pend_rd_i;
            end
        end
    end
endmodule

module regfile_mp #(
    parameter  int XLEN     = 32,
    parameter  int DEPTH    = 32,
    parameter  int NUM_RD   = 2,
    parameter  int BYPASS   = 1,
    parameter  int ZERO_REG = 1,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     EN,
    input  logic [ADDR_W-1:0]        WA,
    input  logic [XLEN-1:0]          WD,
    input  logic                     RSV_EN,
    input  logic [ADDR_W-1:0]        RSV_A,
    input  logic [NUM_RD*ADDR_W-1:0] ADR,
    output logic [NUM_RD*XLEN-1:0]   RS,
    output logic [NUM_RD-1:0]        PEND,
    output logic                     BUSY
);
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic [XLEN-1:0]   mem_q [DEPTH];

    // Single memory write port shared by the clear sequence and normal writes.
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [XLEN-1:0]   mem_wd;

    logic ready;
    logic wr_ok;
    logic rsv_ok;

    assign ready  = (state_q == READY);
    assign wr_ok  = EN     && !((ZERO_REG != 0) && (WA    == '0));
    assign rsv_ok = RSV_EN && !((ZERO_REG != 0) && (RSV_A == '0));

    // BUSY comes from state alone, so there is no path from ADR.
    assign BUSY = !ready;

    // -------------------------------------------------------------------------
    // Next state / write control
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        mem_we  = 1'b0;
        mem_wa  = cnt_q;
        mem_wd  = '0;

        if (!RST) begin
            unique case (state_q)
                CLEAR: begin
                    // EN and RSV_EN are ignored; walk cnt through every entry.
                    mem_we = 1'b1;
                    mem_wa = cnt_q;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = READY;
                    end
                end
                READY: begin
                    if (wr_ok) begin
                        mem_we     = 1'b1;
                        mem_wa     = WA;
                        mem_wd     = WD;
                        pend_d[WA] = 1'b0;
                    end
                    // Applied after the write's clear: a new producer reserving
                    // the same entry in the same cycle keeps it pending.
                    if (rsv_ok) begin
                        pend_d[RSV_A] = 1'b1;
                    end
                end
                default: begin
                    state_d = CLEAR;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    // Storage has no reset; it is zeroed by the clear sequence instead.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    // -------------------------------------------------------------------------
    // Read ports
    // -------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] adr;
        assign adr = ADR[i*ADDR_W +: ADDR_W];

        regfile_mp_rdport #(
            .XLEN     (XLEN),
            .ADDR_W   (ADDR_W),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .ready_i   (ready),
            .adr_i     (adr),
            .mem_rd_i  (mem_q[adr]),
            .pend_rd_i (pend_q[adr]),
            .wr_en_i   (EN),
            .wa_i      (WA),
            .wd_i      (WD),
            .rs_o      (RS[i*XLEN +: XLEN]),
            .pend_o    (PEND[i])
        );
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Two configurations share one stimulus stream:
//   dut_a: NUM_RD=4, BYPASS=1, ZERO_REG=1
//   dut_b: NUM_RD=2, BYPASS=0, ZERO_REG=0 (reads ADR ports 0..1)
module tb_regfile_mp;
    localparam int X = 32;
    localparam int D = 32;
    localparam int A = 5;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         EN = 1'b0;
    logic         RSV_EN = 1'b0;
    logic [A-1:0] WA = '0;
    logic [A-1:0] RSV_A = '0;
    logic [X-1:0] WD = '0;
    logic [4*A-1:0] ADR = '0;

    logic [4*X-1:0] RS_a;
    logic [3:0]     PEND_a;
    logic           BUSY_a;
    logic [2*X-1:0] RS_b;
    logic [1:0]     PEND_b;
    logic           BUSY_b;

    always #5 CLK = ~CLK;

    regfile_mp #(.XLEN(X), .DEPTH(D), .NUM_RD(4), .BYPASS(1), .ZERO_REG(1)) dut_a (
        .CLK(CLK), .RST(RST), .EN(EN), .WA(WA), .WD(WD), .RSV_EN(RSV_EN),
        .RSV_A(RSV_A), .ADR(ADR), .RS(RS_a), .PEND(PEND_a), .BUSY(BUSY_a));

    regfile_mp #(.XLEN(X), .DEPTH(D), .NUM_RD(2), .BYPASS(0), .ZERO_REG(0)) dut_b (
        .CLK(CLK), .RST(RST), .EN(EN), .WA(WA), .WD(WD), .RSV_EN(RSV_EN),
        .RSV_A(RSV_A), .ADR(ADR[2*A-1:0]), .RS(RS_b), .PEND(PEND_b), .BUSY(BUSY_b));

    // Reference model: plain arrays, clear modelled as a countdown that zeroes
    // the whole array when it expires (reads are 0 until then anyway).
    logic [X-1:0] m_mem  [2][D];
    bit           m_pend [2][D];
    int           busy_left = 0;
    bit           known = 1'b0;
    int           checks = 0;
    int           errors = 0;

    function automatic bit cfg_byp(input int k); return k == 0; endfunction
    function automatic bit cfg_zr (input int k); return k == 0; endfunction

    task automatic chk(input string tag, input logic [X-1:0] obs, input logic [X-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_rd(input int k, input logic [A-1:0] ad,
                                     output logic [X-1:0] rs, output logic p);
        rs = '0;
        p  = 1'b0;
        if (busy_left != 0) begin
            rs = '0;
        end else if (cfg_zr(k) && ad == '0) begin
            rs = '0;
        end else if (cfg_byp(k) && EN && WA == ad) begin
            rs = WD;
        end else begin
            rs = m_mem[k][ad];
            p  = m_pend[k][ad];
        end
    endfunction

    task automatic check_all();
        logic [X-1:0] e_rs;
        logic         e_p;
        logic [A-1:0] ad;
        if (!known) return;
        chk("busy_a", X'(BUSY_a), X'(busy_left != 0));
        chk("busy_b", X'(BUSY_b), X'(busy_left != 0));
        for (int i = 0; i < 4; i++) begin
            ad = ADR[i*A +: A];
            model_rd(0, ad, e_rs, e_p);
            chk($sformatf("rs_a%0d@%0d", i, ad), RS_a[i*X +: X], e_rs);
            chk($sformatf("pend_a%0d@%0d", i, ad), X'(PEND_a[i]), X'(e_p));
        end
        for (int i = 0; i < 2; i++) begin
            ad = ADR[i*A +: A];
            model_rd(1, ad, e_rs, e_p);
            chk($sformatf("rs_b%0d@%0d", i, ad), RS_b[i*X +: X], e_rs);
            chk($sformatf("pend_b%0d@%0d", i, ad), X'(PEND_b[i]), X'(e_p));
        end
    endtask

    task automatic model_edge();
        if (RST) begin
            for (int k = 0; k < 2; k++)
                for (int j = 0; j < D; j++) m_pend[k][j] = 1'b0;
            busy_left = D;
            known = 1'b1;
        end else if (known) begin
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0)
                    for (int k = 0; k < 2; k++)
                        for (int j = 0; j < D; j++) m_mem[k][j] = '0;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (EN && !(cfg_zr(k) && WA == '0)) begin
                        m_mem[k][WA]  = WD;
                        m_pend[k][WA] = 1'b0;
                    end
                    if (RSV_EN && !(cfg_zr(k) && RSV_A == '0)) m_pend[k][RSV_A] = 1'b1;
                end
            end
        end
    endtask

    // Check combinational outputs mid-cycle, then advance one clock.
    task automatic cycle();
        @(negedge CLK);
        check_all();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic idle();
        EN = 1'b0; RSV_EN = 1'b0; RST = 1'b0;
    endtask

    task automatic adr_all(input logic [A-1:0] ad);
        ADR = {4{ad}};
    endtask

    initial begin
        // ---- clear sequence: RST for 3 cycles, stray writes to 5 while clearing
        RST = 1'b1;
        repeat (3) cycle();
        RST = 1'b0;
        for (int c = 0; c < D; c++) begin
            EN = (c % 3 == 0); WA = 5'd5; WD = 32'hDEAD;
            ADR = 20'($urandom);
            cycle();
        end
        idle();
        for (int a = 0; a < D; a++) begin
            adr_all(A'(a));
            cycle();
        end

        // ---- write and forward
        EN = 1'b1; WA = 5'd7; WD = 32'h1234ABCD; adr_all(5'd7);
        cycle();
        idle();
        cycle();

        // ---- zero register
        EN = 1'b1; WA = 5'd0; WD = 32'hFFFFFFFF; adr_all(5'd3);
        cycle();
        idle(); RSV_EN = 1'b1; RSV_A = 5'd0; adr_all(5'd0);
        cycle();
        idle();
        cycle();

        // ---- scoreboard on address 9
        RSV_EN = 1'b1; RSV_A = 5'd9; adr_all(5'd9);
        cycle();
        idle();
        cycle();
        EN = 1'b1; WA = 5'd9; WD = 32'h55;
        cycle();
        idle();
        cycle();
        RSV_EN = 1'b1; RSV_A = 5'd9; cycle();
        EN = 1'b1; WA = 5'd9; WD = 32'h77; RSV_EN = 1'b1; RSV_A = 5'd9;
        cycle();
        idle();
        cycle();

        // ---- multi-port
        for (int a = 1; a <= 4; a++) begin
            EN = 1'b1; WA = A'(a); WD = 32'hC0DE0000 + 32'(a * 17); adr_all(5'd0);
            cycle();
        end
        idle();
        ADR = {5'd4, 5'd3, 5'd2, 5'd1};
        cycle();
        adr_all(5'd3);
        cycle();

        // ---- reset mid-clear after a READY period with live data
        EN = 1'b1; WA = 5'd20; WD = 32'hAA; cycle();
        WA = 5'd31; cycle();
        idle(); RSV_EN = 1'b1; RSV_A = 5'd20; cycle();
        idle(); ADR = {5'd31, 5'd20, 5'd31, 5'd20}; cycle();
        RST = 1'b1; cycle();
        RST = 1'b0;
        repeat (10) cycle();
        RST = 1'b1; cycle();
        RST = 1'b0;
        repeat (D) cycle();
        cycle();

        // ---- randomized traffic
        for (int n = 0; n < 400; n++) begin
            RST    = ($urandom_range(0, 199) == 0);
            EN     = 1'($urandom_range(0, 1));
            WA     = A'($urandom_range(0, 15));
            WD     = $urandom;
            RSV_EN = ($urandom_range(0, 2) == 0);
            RSV_A  = A'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++)
                ADR[i*A +: A] = ($urandom_range(0, 3) == 0) ? WA : A'($urandom_range(0, 15));
            cycle();
        end
        idle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
